// File: rtl/spi_frame_fsm.sv
// spi_frame_fsm: brings SPI cs/sck into the clk domain, counts sck rising
// edges per frame and flags each frame as good or bad-length.
module spi_frame_fsm #(
  parameter int FRAME_BITS     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int CS_ACTIVE_HIGH = 1,
  parameter int ONE_SHOT       = 0,
  parameter int CNT_W          = 8,
  localparam int BCW           = $clog2(FRAME_BITS + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sck,
  input  logic             ack,
  output logic             ready,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [BCW-1:0]   bit_count,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic CS_ON   = (CS_ACTIVE_HIGH != 0);
  localparam logic CS_IDLE = ~CS_ON;
  localparam logic [BCW-1:0] N_GOOD = BCW'(FRAME_BITS);
  localparam logic [BCW-1:0] N_SAT  = BCW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic                   cs_d_q;
  logic                   sck_d_q;
  logic                   cs_s;
  logic                   sck_s;
  logic                   cs_act_s;
  logic                   cs_act_d;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   sck_rise;

  state_t                 state_q, state_d;
  logic [BCW-1:0]         cnt_q, cnt_d;
  logic [BCW-1:0]         cnt_n;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic                   ready_q, ready_d;
  logic                   ovr_q, ovr_d;
  logic                   ok_q, ok_d;
  logic                   err_q, err_d;

  // Sync chains reset to the idle pin levels so release makes no edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q  <= {SYNC_STAGES{CS_IDLE}};
      sck_sync_q <= '0;
      cs_d_q     <= CS_IDLE;
      sck_d_q    <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_d_q     <= cs_s;
      sck_d_q    <= sck_s;
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_act_s = ~(cs_s ^ CS_ON);
  assign cs_act_d = ~(cs_d_q ^ CS_ON);
  assign cs_rise  = cs_act_s & ~cs_act_d;
  assign cs_fall  = ~cs_act_s & cs_act_d;
  assign sck_rise = sck_s & ~sck_d_q;

  assign cnt_n = (sck_rise && cnt_q != N_SAT) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    ready_d = ready_q;
    ovr_d   = ovr_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        cnt_d = cnt_n;
        if (cs_fall) begin
          if (cnt_n == N_GOOD) begin
            ok_d    = 1'b1;
            fcnt_d  = fcnt_q + 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        // ack consumes any cs edge arriving in the same cycle
        if (ONE_SHOT == 0) begin
          if (ack) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
            state_d = IDLE;
          end else if (cs_rise) begin
            ovr_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready       = ready_q;
  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q == ACTIVE);
  assign bit_count   = cnt_q;
  assign frame_count = fcnt_q;

endmodule

// File: doc/spi_frame_fsm.md
Name: spi_frame_fsm

Overview:
- Parametrised successor to the single-shot chip-select FSM on the FPGA SPI slave path.
- Synchronises cs and sck into the clk domain and counts sck rising edges per frame.
- Classifies each frame as good (exactly FRAME_BITS bits) or bad, and drives a ready flag for downstream logic.
- Supports the legacy latch-forever behaviour (ONE_SHOT=1) and a re-armable mode with ack, overrun flag and a frame counter.

Parameters:
- FRAME_BITS, 8: required number of sck rising edges per good frame (≥1).
- SYNC_STAGES, 2: synchroniser flops on cs and sck (≥2).
- CS_ACTIVE_HIGH, 1: 1 = cs asserted when high; 0 = asserted when low.
- ONE_SHOT, 0: 1 = after first good frame, stay DONE until reset; 0 = re-arm on ack.
- CNT_W, 8: frame_count width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cs  in  1  raw SPI chip select, asynchronous to clk
- sck  in  1  raw SPI clock, asynchronous to clk
- ack  in  1  consumer acknowledge; clears ready (ONE_SHOT=0 only)
- ready  out  1  level; high while a good frame is held
- frame_ok  out  1  one-cycle pulse per good frame
- frame_err  out  1  one-cycle pulse per bad-length frame
- overrun  out  1  sticky; a frame started while ready was unacknowledged
- busy  out  1  high in ACTIVE
- bit_count  out  $clog2(FRAME_BITS+2)  sck edges in current/last frame
- frame_count  out  CNT_W  good frames since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset: clk, reset use the codebase names. Reset is asynchronous and active-high. All outputs clear to 0 immediately, state = IDLE, and synchroniser flops load the inactive level (cs inactive, sck 0).
- Sync: cs_s/sck_s = last synchroniser stage; cs_d/sck_d = one further register. cs_act = cs_s XNOR CS_ACTIVE_HIGH.
- Edges: cs_rise = assert edge; cs_fall = deassert edge; sck_rise = sck_s & ~sck_d.
- Latency: raw input change to output/state change is SYNC_STAGES+1 clk cycles.
- Timing requirement: clk ≥ 4× sck frequency; sck high and low phases each ≥ 2 clk.
- States:
  - IDLE: on cs_rise → ACTIVE, bit_count←0, busy←1. A cs level already active without an edge (e.g. a frame in progress when ack arrives) is ignored.
  - ACTIVE: each sck_rise increments bit_count, saturating at FRAME_BITS+1. On cs_fall: n = bit_count plus 1 if sck_rise coincides.
    - n == FRAME_BITS → frame_ok pulse, frame_count+1, ready←1, → DONE.
    - Otherwise → frame_err pulse, → IDLE.
    - bit_count holds n in both cases.
  - DONE, ONE_SHOT=1: terminal. ack, cs and sck are ignored; ready stays 1 until reset.
  - DONE, ONE_SHOT=0:
    - ack=1 → ready←0, overrun←0, → IDLE.
    - cs_rise with ack=0 → overrun←1; frame not counted; stay DONE.
    - ack and cs_rise in the same cycle: ack wins. → IDLE, no overrun; that frame is ignored because its edge is consumed.
  - Unused state encodings → IDLE.
- sck edges outside ACTIVE are ignored.
- frame_ok and frame_err are never high in the same cycle.
- Reset mid-frame aborts with no pulse.

Test Plan:
- Power-on: assert reset with no clk edges → all outputs 0 immediately. Release; hold cs inactive 10 clks → outputs stay 0.
- Defaults: cs high, 8 sck pulses (4 clk high / 4 low), cs low → frame_ok for exactly 1 clk, 3 clks after cs falls at the pin. Then ready=1, bit_count=8, frame_count=1, busy=0.
- Short and long frames: 5 pulses → frame_err pulse, bit_count=5, ready=0, frame_count unchanged. 12 pulses → frame_err, bit_count=9 (saturated).
- Overrun and ack: good frame, then a second 8-bit frame with no ack → overrun=1, frame_count stays 1, ready=1. Pulse ack → ready=0, overrun=0. Third good frame → frame_count=2.
- ONE_SHOT=1 and CS_ACTIVE_HIGH=0: cs low, 8 pulses, cs high → ready=1. ack, then a further good frame → ready stays 1, frame_count stays 1. Reset asserted asynchronously → ready=0 at once.
- Wrap/mid-frame reset: CNT_W=2, 4 good frames acked → frame_count=0. Assert reset after 3 sck pulses of a frame → no pulse. After release, the next complete frame counts normally.
